// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: one packet per handshake, load data
// alignment/extension, single-cycle commit pulse, retire counter.
module wb_commit_unit #(
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid_i,
  output logic             wb_ready_o,
  input  logic [XLEN-1:0]  wb_pc_i,
  input  logic             wb_wena_i,
  input  logic [RAW-1:0]   wb_waddr_i,
  input  logic [XLEN-1:0]  wb_result_i,
  input  logic             wb_load_i,
  input  logic [1:0]       wb_lsize_i,
  input  logic             wb_lsign_i,
  input  logic [1:0]       wb_laddr_lo_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             commit_valid_o,
  output logic             commit_wena_o,
  output logic [RAW-1:0]   commit_waddr_o,
  output logic [XLEN-1:0]  commit_wdata_o,
  output logic [XLEN-1:0]  commit_pc_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    COMMIT   = 2'b10
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            wena;
    logic [RAW-1:0]  waddr;
    logic [1:0]      lsize;
    logic            lsign;
    logic [1:0]      lo;
  } ld_t;

  state_t          state_q;
  state_t          state_d;
  ld_t             ld_q;
  logic            accept;
  logic            mem_done;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ld_data;

  assign wb_ready_o = (state_q == IDLE) || (state_q == COMMIT);
  assign accept     = wb_valid_i && wb_ready_o;
  assign mem_done   = (state_q == WAIT_MEM) && mem_rvalid_i;

  // Next state: a new packet in IDLE/COMMIT chains straight on.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, COMMIT: begin
        if (accept)
          state_d = wb_load_i ? WAIT_MEM : COMMIT;
        else
          state_d = IDLE;
      end
      WAIT_MEM: begin
        if (mem_rvalid_i)
          state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane select and extension of the returned load word.
  always_comb begin
    byte_v  = mem_rdata_i[7:0];
    half_v  = ld_q.lo[1] ? mem_rdata_i[31:16]
                         : mem_rdata_i[15:0];
    ld_data = mem_rdata_i;
    unique case (ld_q.lo)
      2'd0: byte_v = mem_rdata_i[7:0];
      2'd1: byte_v = mem_rdata_i[15:8];
      2'd2: byte_v = mem_rdata_i[23:16];
      2'd3: byte_v = mem_rdata_i[31:24];
      default: byte_v = mem_rdata_i[7:0];
    endcase
    unique case (1'b1)
      (ld_q.lsize == 2'b00):
        ld_data = {{(XLEN-8){ld_q.lsign & byte_v[7]}},
                   byte_v};
      (ld_q.lsize == 2'b01):
        ld_data = {{(XLEN-16){ld_q.lsign & half_v[15]}},
                   half_v};
      ld_q.lsize[1]:
        ld_data = mem_rdata_i;
      default: ld_data = mem_rdata_i;
    endcase
  end

  // State register, pending-load fields and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      ld_q           <= '0;
      commit_valid_o <= 1'b0;
      retired_cnt_o  <= '0;
    end else begin
      state_q        <= state_d;
      commit_valid_o <= (state_d == COMMIT);
      retired_cnt_o  <= retired_cnt_o
                      + CNT_W'(commit_valid_o);
      if (accept)
        ld_q <= '{pc:    wb_pc_i,
                  wena:  wb_wena_i,
                  waddr: wb_waddr_i,
                  lsize: wb_lsize_i,
                  lsign: wb_lsign_i,
                  lo:    wb_laddr_lo_i};
    end
  end

  // Commit outputs load only on entry to COMMIT, else hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_wena_o  <= 1'b0;
      commit_waddr_o <= '0;
      commit_wdata_o <= '0;
      commit_pc_o    <= '0;
    end else if (accept && !wb_load_i) begin
      commit_wena_o  <= wb_wena_i;
      commit_waddr_o <= wb_waddr_i;
      commit_wdata_o <= wb_result_i;
      commit_pc_o    <= wb_pc_i;
    end else if (mem_done) begin
      commit_wena_o  <= ld_q.wena;
      commit_waddr_o <= ld_q.waddr;
      commit_wdata_o <= ld_data;
      commit_pc_o    <= ld_q.pc;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed steps, expected commits
// queued at drive time and popped when a commit pulse appears.
module tb_wb_commit_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid_i = 1'b0;
  logic        wb_ready_o;
  logic [31:0] wb_pc_i = '0;
  logic        wb_wena_i = 1'b0;
  logic [4:0]  wb_waddr_i = '0;
  logic [31:0] wb_result_i = '0;
  logic        wb_load_i = 1'b0;
  logic [1:0]  wb_lsize_i = '0;
  logic        wb_lsign_i = 1'b0;
  logic [1:0]  wb_laddr_lo_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        commit_valid_o;
  logic        commit_wena_o;
  logic [4:0]  commit_waddr_o;
  logic [31:0] commit_wdata_o;
  logic [31:0] commit_pc_o;
  logic [63:0] retired_cnt_o;

  typedef struct packed {
    logic [31:0] pc;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;

  always #5 clock = ~clock;

  wb_commit_unit dut (
    .clock          (clock),
    .reset          (reset),
    .wb_valid_i     (wb_valid_i),
    .wb_ready_o     (wb_ready_o),
    .wb_pc_i        (wb_pc_i),
    .wb_wena_i      (wb_wena_i),
    .wb_waddr_i     (wb_waddr_i),
    .wb_result_i    (wb_result_i),
    .wb_load_i      (wb_load_i),
    .wb_lsize_i     (wb_lsize_i),
    .wb_lsign_i     (wb_lsign_i),
    .wb_laddr_lo_i  (wb_laddr_lo_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .commit_valid_o (commit_valid_o),
    .commit_wena_o  (commit_wena_o),
    .commit_waddr_o (commit_waddr_o),
    .commit_wdata_o (commit_wdata_o),
    .commit_pc_o    (commit_pc_o),
    .retired_cnt_o  (retired_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic [31:0] pc,
                     input logic [4:0] rd,
                     input logic we,
                     input logic [31:0] res);
    wb_valid_i  = 1'b1;
    wb_load_i   = 1'b0;
    wb_pc_i     = pc;
    wb_waddr_i  = rd;
    wb_wena_i   = we;
    wb_result_i = res;
    q.push_back('{pc: pc, wena: we, waddr: rd,
                  wdata: res});
    exp_cnt++;
  endtask

  task automatic drive_load(input logic [31:0] pc,
                            input logic [4:0] rd,
                            input logic [1:0] sz,
                            input logic sg,
                            input logic [1:0] lo);
    wb_valid_i    = 1'b1;
    wb_load_i     = 1'b1;
    wb_pc_i       = pc;
    wb_waddr_i    = rd;
    wb_wena_i     = 1'b1;
    wb_lsize_i    = sz;
    wb_lsign_i    = sg;
    wb_laddr_lo_i = lo;
    wb_result_i   = 32'hDEAD_BEEF;
  endtask

  task automatic load(input logic [31:0] pc,
                      input logic [4:0] rd,
                      input logic [1:0] sz,
                      input logic sg,
                      input logic [1:0] lo,
                      input logic [31:0] rdata,
                      input int delay,
                      input logic [31:0] exp);
    drive_load(pc, rd, sz, sg, lo);
    q.push_back('{pc: pc, wena: 1'b1, waddr: rd,
                  wdata: exp});
    exp_cnt++;
    tick();
    wb_valid_i = 1'b0;
    wb_load_i  = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      chk("wait_ready", 64'(wb_ready_o), 64'd0);
      chk("wait_valid", 64'(commit_valid_o), 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clock);
    chk("rv_ready", 64'(wb_ready_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    @(negedge clock);
    chk("ld_commit", 64'(commit_valid_o), 64'd1);
    tick();
    @(negedge clock);
    chk("ld_single", 64'(commit_valid_o), 64'd0);
  endtask

  // Scoreboard: every commit pulse must match the oldest entry.
  always @(negedge clock) begin
    if (!reset && commit_valid_o) begin
      exp_t obs;
      exp_t exp;
      obs = '{pc: commit_pc_o, wena: commit_wena_o,
              waddr: commit_waddr_o,
              wdata: commit_wdata_o};
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_commit: got %h expected none",
               obs);
      end else begin
        exp = q.pop_front();
        assert (obs === exp) else begin
          miscompares++;
          $error("FAIL commit: got %h expected %h",
                 obs, exp);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    @(negedge clock);
    chk("rst_valid", 64'(commit_valid_o), 64'd0);
    chk("rst_ready", 64'(wb_ready_o), 64'd1);
    chk("rst_cnt", retired_cnt_o, 64'd0);
    chk("rst_wdata", 64'(commit_wdata_o), 64'd0);
    chk("rst_pc", 64'(commit_pc_o), 64'd0);
    tick();
    reset = 1'b0;

    alu(32'h100, 5'd5, 1'b1, 32'h11);
    tick();
    alu(32'h104, 5'd6, 1'b1, 32'h22);
    @(negedge clock);
    chk("b2b_1", 64'(commit_valid_o), 64'd1);
    chk("b2b_ready", 64'(wb_ready_o), 64'd1);
    tick();
    wb_valid_i = 1'b0;
    @(negedge clock);
    chk("b2b_2", 64'(commit_valid_o), 64'd1);
    tick();
    @(negedge clock);
    chk("b2b_end", 64'(commit_valid_o), 64'd0);
    chk("b2b_cnt", retired_cnt_o, 64'd2);
    chk("hold_wdata", 64'(commit_wdata_o), 64'h22);

    load(32'h140, 5'd9, 2'b00, 1'b1, 2'd2,
         32'h12F0_3456, 0, 32'hFFFF_FFF0);
    load(32'h144, 5'd9, 2'b00, 1'b0, 2'd2,
         32'h12F0_3456, 1, 32'h0000_00F0);
    load(32'h148, 5'd10, 2'b00, 1'b1, 2'd0,
         32'h12F0_3456, 0, 32'h0000_0056);
    load(32'h14C, 5'd11, 2'b01, 1'b0, 2'd2,
         32'h8001_7FFF, 0, 32'h0000_8001);
    load(32'h150, 5'd11, 2'b01, 1'b1, 2'd2,
         32'h8001_7FFF, 0, 32'hFFFF_8001);
    load(32'h154, 5'd12, 2'b01, 1'b1, 2'd0,
         32'h8001_7FFF, 0, 32'h0000_7FFF);
    load(32'h158, 5'd13, 2'b10, 1'b1, 2'd0,
         32'h8001_7FFF, 0, 32'h8001_7FFF);
    load(32'h15C, 5'd14, 2'b11, 1'b1, 2'd3,
         32'hC3A5_0F1E, 3, 32'hC3A5_0F1E);

    alu(32'h200, 5'd7, 1'b1, 32'hAAAA_5555);
    tick();
    drive_load(32'h204, 5'd8, 2'b10, 1'b0, 2'd0);
    q.push_back('{pc: 32'h204, wena: 1'b1,
                  waddr: 5'd8, wdata: 32'h1357_9BDF});
    exp_cnt++;
    @(negedge clock);
    chk("chain_alu", 64'(commit_valid_o), 64'd1);
    tick();
    wb_valid_i = 1'b0;
    wb_load_i  = 1'b0;
    @(negedge clock);
    chk("chain_wait", 64'(commit_valid_o), 64'd0);
    chk("chain_hold_pc", 64'(commit_pc_o), 64'h200);
    chk("chain_hold_wd", 64'(commit_wdata_o),
        64'hAAAA_5555);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1357_9BDF;
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clock);
    chk("chain_ld", 64'(commit_valid_o), 64'd1);
    tick();
    @(negedge clock);
    chk("pre_rst_cnt", retired_cnt_o, 64'(exp_cnt));

    drive_load(32'h300, 5'd15, 2'b10, 1'b0, 2'd0);
    tick();
    wb_valid_i   = 1'b0;
    wb_load_i    = 1'b0;
    reset        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0BAD_0BAD;
    tick();
    reset = 1'b0;
    tick();
    mem_rvalid_i = 1'b0;
    exp_cnt = 0;
    @(negedge clock);
    chk("rstw_valid", 64'(commit_valid_o), 64'd0);
    chk("rstw_ready", 64'(wb_ready_o), 64'd1);
    chk("rstw_cnt", retired_cnt_o, 64'd0);
    tick();
    @(negedge clock);
    chk("rstw_valid2", 64'(commit_valid_o), 64'd0);

    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clock);
    chk("stray_valid", 64'(commit_valid_o), 64'd0);
    chk("stray_ready", 64'(wb_ready_o), 64'd1);

    alu(32'h400, 5'd0, 1'b1, 32'h55);
    tick();
    wb_valid_i = 1'b0;
    @(negedge clock);
    chk("x0_valid", 64'(commit_valid_o), 64'd1);
    chk("x0_wena", 64'(commit_wena_o), 64'd1);
    chk("x0_waddr", 64'(commit_waddr_o), 64'd0);
    alu(32'h404, 5'd3, 1'b0, 32'h66);
    tick();
    wb_valid_i = 1'b0;
    @(negedge clock);
    chk("nowe_wena", 64'(commit_wena_o), 64'd0);
    repeat (3) tick();
    @(negedge clock);
    chk("end_valid", 64'(commit_valid_o), 64'd0);
    chk("end_cnt", retired_cnt_o, 64'(exp_cnt));
    chk("end_queue", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
